vga_scanout: RTL
================

# vga_scanout

Parametrised VGA scan-out engine: generates display timing, fetches palette indices from a double-buffered frame RAM read port, and drives registered RGB/sync/enable to the DVI transmitter. Successor to the fixed-timing 1280x800 scan-out: it makes RAM read latency a parameter, handshakes buffer swaps with the renderer, and latches the shade level per frame. It also treats palette index 0 as transparent, so the shaded background shows through. It sits entirely in the pixel-clock domain; the renderer owns the frame RAM write port.

## Interface
- COOR_WIDTH, 12, counter/coordinate width
- HSIZE / HFP / HSP / HMAX, 1280 / 1344 / 1480 / 1680, horizontal active end, sync start, sync end, total
- VSIZE / VFP / VSP / VMAX, 800 / 801 / 804 / 828, vertical equivalents
- HSPP / VSPP, 1 / 1, sync active level
- FRAME_LEFT / FRAME_RIGHT / FRAME_TOP / FRAME_BOTTOM, 0 / 1280 / 250 / 550, RAM-backed window, right/bottom exclusive
- RAM_WIDTH, 20, frame RAM address width
- PIXEL_WIDTH, 3, palette index width
- RAM_LATENCY, 2, cycles from ram_rdaddr to ram_q valid; must be 1 or more
- SHADE_WIDTH, 6, shade width; MAX_SHADE = 2^SHADE_WIDTH-1
- clk_vga  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- swap_req  in  1  one-cycle request from the renderer to swap buffers
- swap_ack  out  1  one-cycle pulse when the swap takes effect
- read_part  out  1  buffer being displayed; the renderer writes ~read_part
- frame_start  out  1  pulse at counter (0,0)
- vblank  out  1  counter y >= VSIZE
- shade  in  SHADE_WIDTH  0 is white background, MAX_SHADE is black
- ram_rden  out  1  counter inside window
- ram_rdaddr  out  RAM_WIDTH  frame RAM read address
- ram_q  in  PIXEL_WIDTH  read data
- pal_index  out  PIXEL_WIDTH  ram_q passed through combinationally
- pal_rgb  in  24  combinational palette colour for pal_index, {r,g,b}
- hsync, vsync, data_enable  out  1  registered
- red, green, blue  out  8  registered

## Operation
- Stage-0 counters x,y: x wraps at HMAX-1 to 0; y increments on x wrap and wraps at VMAX-1 to 0.
- Coordinates pass through a delay line RAM_LATENCY deep. Stage-L coordinates drive all output registers.
- Address generation: FW = FRAME_RIGHT-FRAME_LEFT, FH = FRAME_BOTTOM-FRAME_TOP, RAM_SIZE = FW*FH.
- ram_rdaddr = read_part*RAM_SIZE + (x-FRAME_LEFT) + (y-FRAME_TOP)*FW, combinational from stage 0. ram_rden gates it.
- Swap handshake:
  - swap_req sets a pending flag.
  - At the boundary cycle (x==0, y==VSIZE): if pending, or swap_req is high in that same cycle, read_part toggles, swap_ack pulses, and pending clears.
  - Multiple requests within one frame produce one swap.
  - A request arriving after the boundary waits for the next frame.
- Shade latch: shade is sampled into shade_q at frame_start, so mid-frame changes do not tear.
  - bg = 255 - floor(shade_q*255/MAX_SHADE), computed at width 8+SHADE_WIDTH.
- Output selection at stage L:
  - Inside the window with pal_index != 0: pal_rgb.
  - Inside the window with index 0, or active area outside the window: bg on all three channels.
  - Outside the active area: 0.
- Sync outputs from stage-L coordinates:
  - hsync = HSPP when HFP <= x < HSP, else !HSPP. vsync is the same on the vertical axis.
  - data_enable = x<HSIZE && y<VSIZE.

## Timing
- Reset values:
  - counters, read_part, pending, shade_q: 0
  - swap_ack, frame_start, data_enable, red, green, blue: 0
  - hsync = !HSPP, vsync = !VSPP
  - delay line: zero coordinates
- rst_n deassertion is synchronised internally (2 flops). The first counter increment happens 2 cycles after release.
- Latency: a counter value reaches the output pins RAM_LATENCY+1 cycles later, for sync, enable and colour alike.
- swap_ack, read_part toggle, frame_start and vblank are stage-0 aligned.
  - swap_ack and the read_part change take effect the cycle after the boundary counter value.
  - The new read_part affects ram_rdaddr from that cycle.
- Reset mid-frame: all state returns to its reset value immediately, and a pending swap is dropped.

## Configuration
- VGA_SCALE2_EN defined: each RAM pixel covers a 2x2 screen block.
  - RAM_SIZE = (FW/2)*(FH/2).
  - Address uses (x-FRAME_LEFT)>>1 + ((y-FRAME_TOP)>>1)*(FW/2).
  - FW and FH must be even.
- VGA_SCALE2_EN undefined: 1:1 mapping as described in Operation.

## Test plan
- Small timing (HSIZE 8, HFP 9, HSP 11, HMAX 12, VSIZE 4, VFP 5, VSP 6, VMAX 7, full-window frame), with rst_n held low then released:
  - outputs hold their reset values while rst_n is low;
  - after release, hsync is active for 2 cycles per 12-cycle line;
  - frame_start fires every 84 cycles.
- Default timing, RAM model with RAM_LATENCY=2 returning index 5, pal_rgb=24'h123456 for index 5:
  - {red,green,blue} = 12,34,56 hex, 3 cycles after ram_rdaddr shows the window pixel;
  - data_enable is aligned with the colour.
- swap_req pulsed twice in one frame, at y=300:
  - exactly one swap_ack, at (0,800);
  - read_part=1;
  - the next window-origin ram_rdaddr = 384000.
- swap_req pulsed exactly at the (0,800) boundary cycle: the swap happens in that frame.
- Shade values:
  - shade=0 gives bg 255;
  - shade=21 gives bg 170;
  - shade=63 gives bg 0;
  - shade changed mid-frame has no effect until the next frame_start;
  - index 0 inside the window outputs bg.
- VGA_SCALE2_EN: screen (0,250),(1,250),(0,251),(1,251) share address 0, and (2,250) reads address 1.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing, double-buffered frame RAM fetch and registered RGB/sync output; define VGA_SCALE2_EN for 2x2 pixel scaling
module vga_scanout #(
  parameter int COOR_WIDTH = 12,
  parameter int HSIZE = 1280,
  parameter int HFP = 1344,
  parameter int HSP = 1480,
  parameter int HMAX = 1680,
  parameter int VSIZE = 800,
  parameter int VFP = 801,
  parameter int VSP = 804,
  parameter int VMAX = 828,
  parameter logic HSPP = 1'b1,
  parameter logic VSPP = 1'b1,
  parameter int FRAME_LEFT = 0,
  parameter int FRAME_RIGHT = 1280,
  parameter int FRAME_TOP = 250,
  parameter int FRAME_BOTTOM = 550,
  parameter int RAM_WIDTH = 20,
  parameter int PIXEL_WIDTH = 3,
  parameter int RAM_LATENCY = 2,
  parameter int SHADE_WIDTH = 6
) (
  input  logic                   clk_vga,
  input  logic                   rst_n,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   read_part,
  output logic                   frame_start,
  output logic                   vblank,
  input  logic [SHADE_WIDTH-1:0] shade,
  output logic                   ram_rden,
  output logic [RAM_WIDTH-1:0]   ram_rdaddr,
  input  logic [PIXEL_WIDTH-1:0] ram_q,
  output logic [PIXEL_WIDTH-1:0] pal_index,
  input  logic [23:0]            pal_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   data_enable,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue
);
  localparam int FW = FRAME_RIGHT - FRAME_LEFT;
  localparam int FH = FRAME_BOTTOM - FRAME_TOP;
  localparam int MAX_SHADE = (1 << SHADE_WIDTH) - 1;
  localparam int BW = 8 + SHADE_WIDTH;
`ifdef VGA_SCALE2_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif
  localparam int AW = FW >> SC;
  localparam int RAM_SIZE = AW * (FH >> SC);
  logic [1:0] rs;
  logic run;
  logic [COOR_WIDTH-1:0] x, y, nx, ny, lx, ly;
  logic [COOR_WIDTH-1:0] dx [RAM_LATENCY];
  logic [COOR_WIDTH-1:0] dy [RAM_LATENCY];
  logic pending, boundary, swap, active;
  logic [SHADE_WIDTH-1:0] shade_q;
  logic [7:0] bg;
  logic [RAM_WIDTH-1:0] xo, yo;
  function automatic logic in_win(input logic [COOR_WIDTH-1:0] cx, input logic [COOR_WIDTH-1:0] cy);
    return (cx - COOR_WIDTH'(FRAME_LEFT)) < COOR_WIDTH'(FW) && (cy - COOR_WIDTH'(FRAME_TOP)) < COOR_WIDTH'(FH);
  endfunction
  assign run = rs[1];
  assign nx = (x == COOR_WIDTH'(HMAX - 1)) ? '0 : x + COOR_WIDTH'(1);
  assign ny = (x != COOR_WIDTH'(HMAX - 1)) ? y : (y == COOR_WIDTH'(VMAX - 1)) ? '0 : y + COOR_WIDTH'(1);
  assign boundary = x == '0 && y == COOR_WIDTH'(VSIZE);
  assign swap = boundary && (pending || swap_req);
  assign vblank = y >= COOR_WIDTH'(VSIZE);
  assign ram_rden = in_win(x, y);
  assign xo = RAM_WIDTH'(x - COOR_WIDTH'(FRAME_LEFT)) >> SC;
  assign yo = RAM_WIDTH'(y - COOR_WIDTH'(FRAME_TOP)) >> SC;
  assign ram_rdaddr = (read_part ? RAM_WIDTH'(RAM_SIZE) : '0) + xo + yo * RAM_WIDTH'(AW);
  assign pal_index = ram_q;
  assign lx = dx[RAM_LATENCY-1];
  assign ly = dy[RAM_LATENCY-1];
  assign active = lx < COOR_WIDTH'(HSIZE) && ly < COOR_WIDTH'(VSIZE);
  assign bg = 8'(BW'(255) - BW'(shade_q) * BW'(255) / BW'(MAX_SHADE));
  // Two-flop release synchroniser; everything else idles until run rises
  always_ff @(posedge clk_vga or negedge rst_n)
    if (!rst_n) rs <= '0;
    else rs <= {rs[0], 1'b1};
  // Stage-0 counters, swap handshake, per-frame shade latch and coordinate delay line
  always_ff @(posedge clk_vga or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      read_part <= 1'b0;
      pending <= 1'b0;
      swap_ack <= 1'b0;
      frame_start <= 1'b0;
      shade_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        dx[i] <= '0;
        dy[i] <= '0;
      end
    end else if (run) begin
      x <= nx;
      y <= ny;
      swap_ack <= swap;
      read_part <= read_part ^ swap;
      pending <= !boundary && (pending || swap_req);
      frame_start <= nx == '0 && ny == '0;
      shade_q <= frame_start ? shade : shade_q;
      dx[0] <= x;
      dy[0] <= y;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        dx[i] <= dx[i-1];
        dy[i] <= dy[i-1];
      end
    end
  // Output registers driven from the coordinates that line up with ram_q
  always_ff @(posedge clk_vga or negedge rst_n)
    if (!rst_n) begin
      hsync <= !HSPP;
      vsync <= !VSPP;
      data_enable <= 1'b0;
      {red, green, blue} <= '0;
    end else if (run) begin
      hsync <= (lx >= COOR_WIDTH'(HFP) && lx < COOR_WIDTH'(HSP)) ? HSPP : !HSPP;
      vsync <= (ly >= COOR_WIDTH'(VFP) && ly < COOR_WIDTH'(VSP)) ? VSPP : !VSPP;
      data_enable <= active;
      {red, green, blue} <= !active ? '0 : (in_win(lx, ly) && pal_index != '0) ? pal_rgb : {3{bg}};
    end
endmodule
